// File: rtl/retire_pipe.sv
// ---------------------------------------------------------------------------
// retire_pipe
//
// Post-execute pipeline registers (E->M, M->W, W->U) of the 6-stage core.
// Presents destination tags, gated write enables and forwarding data for the
// forwarding unit, drives the register-file write port from W, and raises the
// load-use stall request when the E-stage consumer needs a load still in M.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   validE/rdE/RegWriteE/      E-stage instruction entering M
//   MemReadE/alu_resultE
//   load_dataM                 data-memory read data for the load in M
//   rs1E, rs2E                 source registers of the instruction in E
//   stall_m, flush_m           hold M / kill the instruction entering M
//   rdM/rdW/rdU                raw stage destination tags
//   RegWriteM/W/U              valid & regwrite & (rd != x0)
//   fwd_dataM/W/U              forwarding data (codes 01/10/11)
//   rf_we/rf_waddr/rf_wdata    register-file write port (from W)
//   load_use_stall             load in M feeds rs1E or rs2E
//   retired_cnt                (only with RETIRE_COUNT_EN) 64-bit count of
//                              valid instructions that moved from W to U
//
// Optional feature macro: RETIRE_COUNT_EN
// ---------------------------------------------------------------------------
module retire_pipe #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              validE,
    input  logic [REG_AW-1:0] rdE,
    input  logic              RegWriteE,
    input  logic              MemReadE,
    input  logic [XLEN-1:0]   alu_resultE,
    input  logic [XLEN-1:0]   load_dataM,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic              stall_m,
    input  logic              flush_m,
    output logic [REG_AW-1:0] rdM,
    output logic [REG_AW-1:0] rdW,
    output logic [REG_AW-1:0] rdU,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic              RegWriteU,
    output logic [XLEN-1:0]   fwd_dataM,
    output logic [XLEN-1:0]   fwd_dataW,
    output logic [XLEN-1:0]   fwd_dataU,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
`ifdef RETIRE_COUNT_EN
    output logic [63:0]       retired_cnt,
`endif
    output logic              load_use_stall
);

    // Stage registers
    logic              validM_q, validM_d;
    logic [REG_AW-1:0] rdM_q, rdM_d;
    logic              regwriteM_q, regwriteM_d;
    logic              memreadM_q, memreadM_d;
    logic [XLEN-1:0]   dataM_q, dataM_d;

    logic              validW_q, validW_d;
    logic [REG_AW-1:0] rdW_q, rdW_d;
    logic              regwriteW_q, regwriteW_d;
    logic [XLEN-1:0]   dataW_q, dataW_d;

    logic              validU_q, validU_d;
    logic [REG_AW-1:0] rdU_q, rdU_d;
    logic              regwriteU_q, regwriteU_d;
    logic [XLEN-1:0]   dataU_q, dataU_d;

`ifdef RETIRE_COUNT_EN
    logic [63:0]       retiredCnt_q, retiredCnt_d;
`endif

    // Next-state for M, W and U. Flush wins over stall in M; while M is
    // stalled, W takes a bubble so the resident M instruction is not
    // duplicated. Flush+stall lets the old M contents advance into W.
    always_comb begin
        validM_d    = validM_q;
        rdM_d       = rdM_q;
        regwriteM_d = regwriteM_q;
        memreadM_d  = memreadM_q;
        dataM_d     = dataM_q;
        if (flush_m) begin
            validM_d = 1'b0;
        end else if (!stall_m) begin
            validM_d    = validE;
            rdM_d       = rdE;
            regwriteM_d = RegWriteE;
            memreadM_d  = MemReadE;
            dataM_d     = alu_resultE;
        end

        validW_d    = validW_q;
        rdW_d       = rdW_q;
        regwriteW_d = regwriteW_q;
        dataW_d     = dataW_q;
        if (stall_m && !flush_m) begin
            validW_d = 1'b0;
        end else begin
            validW_d    = validM_q;
            rdW_d       = rdM_q;
            regwriteW_d = regwriteM_q;
            // Loads pick up memory data here; M only ever holds the address.
            dataW_d     = memreadM_q ? load_dataM : dataM_q;
        end

        validU_d    = validW_q;
        rdU_d       = rdW_q;
        regwriteU_d = regwriteW_q;
        dataU_d     = dataW_q;

`ifdef RETIRE_COUNT_EN
        retiredCnt_d = retiredCnt_q;
        if (validW_q) begin
            retiredCnt_d = retiredCnt_q + 64'd1;
        end
`endif
    end

    // Pipeline state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validM_q    <= 1'b0;
            rdM_q       <= '0;
            regwriteM_q <= 1'b0;
            memreadM_q  <= 1'b0;
            dataM_q     <= '0;
            validW_q    <= 1'b0;
            rdW_q       <= '0;
            regwriteW_q <= 1'b0;
            dataW_q     <= '0;
            validU_q    <= 1'b0;
            rdU_q       <= '0;
            regwriteU_q <= 1'b0;
            dataU_q     <= '0;
        end else begin
            validM_q    <= validM_d;
            rdM_q       <= rdM_d;
            regwriteM_q <= regwriteM_d;
            memreadM_q  <= memreadM_d;
            dataM_q     <= dataM_d;
            validW_q    <= validW_d;
            rdW_q       <= rdW_d;
            regwriteW_q <= regwriteW_d;
            dataW_q     <= dataW_d;
            validU_q    <= validU_d;
            rdU_q       <= rdU_d;
            regwriteU_q <= regwriteU_d;
            dataU_q     <= dataU_d;
        end
    end

`ifdef RETIRE_COUNT_EN
    // Retirement counter, wraps naturally at 2^64.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retiredCnt_q <= '0;
        end else begin
            retiredCnt_q <= retiredCnt_d;
        end
    end

    assign retired_cnt = retiredCnt_q;
`endif

    // Write enables are never raised for x0.
    assign RegWriteM = validM_q & regwriteM_q & (rdM_q != '0);
    assign RegWriteW = validW_q & regwriteW_q & (rdW_q != '0);
    assign RegWriteU = validU_q & regwriteU_q & (rdU_q != '0);

    assign rdM       = rdM_q;
    assign rdW       = rdW_q;
    assign rdU       = rdU_q;

    assign fwd_dataM = dataM_q;
    assign fwd_dataW = dataW_q;
    assign fwd_dataU = dataU_q;

    assign rf_we     = RegWriteW;
    assign rf_waddr  = rdW_q;
    assign rf_wdata  = dataW_q;

    // A load in M cannot forward yet; the consumer in E must wait a cycle.
    assign load_use_stall = validM_q & memreadM_q & (rdM_q != '0) &
                            ((rdM_q == rs1E) | (rdM_q == rs2E));

endmodule

// File: tb/tb_retire_pipe.sv
// ---------------------------------------------------------------------------
// tb_retire_pipe
//
// Directed-vector bench for retire_pipe. Each vector pushes its hand-computed
// expected outputs (tagged with the cycle they apply to) into a scoreboard
// queue; a separate monitor compares them against the DUT mid-cycle.
// ---------------------------------------------------------------------------
module tb_retire_pipe;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Field selectors used by the scoreboard
    localparam int F_RDM  = 0;
    localparam int F_RDW  = 1;
    localparam int F_RDU  = 2;
    localparam int F_RWM  = 3;
    localparam int F_RWW  = 4;
    localparam int F_RWU  = 5;
    localparam int F_FWDM = 6;
    localparam int F_FWDW = 7;
    localparam int F_FWDU = 8;
    localparam int F_WE   = 9;
    localparam int F_WA   = 10;
    localparam int F_WD   = 11;
    localparam int F_LUS  = 12;
    localparam int F_CNT  = 13;

    logic              clk;
    logic              rst_n;
    logic              validE;
    logic [REG_AW-1:0] rdE;
    logic              RegWriteE;
    logic              MemReadE;
    logic [XLEN-1:0]   alu_resultE;
    logic [XLEN-1:0]   load_dataM;
    logic [REG_AW-1:0] rs1E;
    logic [REG_AW-1:0] rs2E;
    logic              stall_m;
    logic              flush_m;
    logic [REG_AW-1:0] rdM, rdW, rdU;
    logic              RegWriteM, RegWriteW, RegWriteU;
    logic [XLEN-1:0]   fwd_dataM, fwd_dataW, fwd_dataU;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              load_use_stall;
`ifdef RETIRE_COUNT_EN
    logic [63:0]       retired_cnt;
`endif

    typedef struct {
        int          cyc;
        int          field;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t scoreQ[$];
    int   cyc;
    int   compared;
    int   mismatched;
    int   scanIdx;

    retire_pipe #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .validE         (validE),
        .rdE            (rdE),
        .RegWriteE      (RegWriteE),
        .MemReadE       (MemReadE),
        .alu_resultE    (alu_resultE),
        .load_dataM     (load_dataM),
        .rs1E           (rs1E),
        .rs2E           (rs2E),
        .stall_m        (stall_m),
        .flush_m        (flush_m),
        .rdM            (rdM),
        .rdW            (rdW),
        .rdU            (rdU),
        .RegWriteM      (RegWriteM),
        .RegWriteW      (RegWriteW),
        .RegWriteU      (RegWriteU),
        .fwd_dataM      (fwd_dataM),
        .fwd_dataW      (fwd_dataW),
        .fwd_dataU      (fwd_dataU),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
`ifdef RETIRE_COUNT_EN
        .retired_cnt    (retired_cnt),
`endif
        .load_use_stall (load_use_stall)
    );

    // Free-running clock and cycle counter; cycle N starts at the Nth edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case something wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] getField(input int f);
        logic [63:0] r;
        r = '0;
        case (f)
            F_RDM:  r = 64'(rdM);
            F_RDW:  r = 64'(rdW);
            F_RDU:  r = 64'(rdU);
            F_RWM:  r = 64'(RegWriteM);
            F_RWW:  r = 64'(RegWriteW);
            F_RWU:  r = 64'(RegWriteU);
            F_FWDM: r = 64'(fwd_dataM);
            F_FWDW: r = 64'(fwd_dataW);
            F_FWDU: r = 64'(fwd_dataU);
            F_WE:   r = 64'(rf_we);
            F_WA:   r = 64'(rf_waddr);
            F_WD:   r = 64'(rf_wdata);
            F_LUS:  r = 64'(load_use_stall);
`ifdef RETIRE_COUNT_EN
            F_CNT:  r = retired_cnt;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic expectOutput(input int atCyc, input int field,
                                input logic [63:0] val, input string name);
        exp_t e;
        e.cyc   = atCyc;
        e.field = field;
        e.val   = val;
        e.name  = name;
        scoreQ.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [63:0] actual;
        actual = getField(e.field);
        compared++;
        if (actual !== e.val) begin
            mismatched++;
            $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h",
                     e.name, e.cyc, actual, e.val);
        end
    endtask

    // Monitor: mid-cycle, compare every expectation due this cycle; any
    // expectation whose cycle has already gone by counts as missed.
    always @(negedge clk) begin
        scanIdx = 0;
        while (scanIdx < scoreQ.size()) begin
            if (scoreQ[scanIdx].cyc == cyc) begin
                checkOutput(scoreQ[scanIdx]);
                scoreQ.delete(scanIdx);
            end else if (scoreQ[scanIdx].cyc < cyc) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL %s: got no check at cycle %0d, expected one",
                         scoreQ[scanIdx].name, scoreQ[scanIdx].cyc);
                scoreQ.delete(scanIdx);
            end else begin
                scanIdx++;
            end
        end
    end

    // Drive one cycle of E-stage inputs just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [REG_AW-1:0] rd,
                                 input logic rw, input logic mr,
                                 input logic [XLEN-1:0] alu,
                                 input logic [XLEN-1:0] ld,
                                 input logic [REG_AW-1:0] r1,
                                 input logic [REG_AW-1:0] r2,
                                 input logic st, input logic fl);
        @(posedge clk);
        #1;
        validE      = v;
        rdE         = rd;
        RegWriteE   = rw;
        MemReadE    = mr;
        alu_resultE = alu;
        load_dataM  = ld;
        rs1E        = r1;
        rs2E        = r2;
        stall_m     = st;
        flush_m     = fl;
    endtask

    task automatic bubble();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    int c;
    int t0;

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n       = 1'b0;
        validE      = 1'b0;
        rdE         = '0;
        RegWriteE   = 1'b0;
        MemReadE    = 1'b0;
        alu_resultE = '0;
        load_dataM  = '0;
        rs1E        = '0;
        rs2E        = '0;
        stall_m     = 1'b0;
        flush_m     = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        bubble();
        c = cyc;
        expectOutput(c, F_WE,   0, "rst_rf_we");
        expectOutput(c, F_RWU,  0, "rst_RegWriteU");
        expectOutput(c, F_FWDU, 0, "rst_fwd_dataU");
        expectOutput(c, F_LUS,  0, "rst_load_use_stall");
`ifdef RETIRE_COUNT_EN
        expectOutput(c, F_CNT,  0, "rst_retired_cnt");
`endif

        // ALU chain through M, W, U; a later rs1 match on a non-load must not stall
        applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 32'h1234, '0, '0, '0, 1'b0, 1'b0);
        c = cyc;
        expectOutput(c + 1, F_RDM,  5,       "alu_rdM");
        expectOutput(c + 1, F_RWM,  1,       "alu_RegWriteM");
        expectOutput(c + 1, F_FWDM, 32'h1234, "alu_fwd_dataM");
        expectOutput(c + 1, F_LUS,  0,       "alu_no_stall");
        expectOutput(c + 2, F_RDW,  5,       "alu_rdW");
        expectOutput(c + 2, F_WE,   1,       "alu_rf_we");
        expectOutput(c + 2, F_WA,   5,       "alu_rf_waddr");
        expectOutput(c + 2, F_WD,   32'h1234, "alu_rf_wdata");
        expectOutput(c + 3, F_RWU,  1,       "alu_RegWriteU");
        expectOutput(c + 3, F_FWDU, 32'h1234, "alu_fwd_dataU");
        expectOutput(c + 3, F_WE,   0,       "alu_rf_we_done");
        expectOutput(c + 4, F_RWU,  0,       "alu_U_clear");
        expectOutput(c + 4, F_RWM,  0,       "alu_M_clear");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 5'd5, '0, 1'b0, 1'b0);
        repeat (3) bubble();

        // Load to x7 consumed via rs1 in the next cycle
        applyStimulus(1'b1, 5'd7, 1'b1, 1'b1, 32'h100, '0, '0, '0, 1'b0, 1'b0);
        c = cyc;
        expectOutput(c + 1, F_LUS,  1,            "ld_stall_rs1");
        expectOutput(c + 1, F_FWDM, 32'h100,      "ld_fwd_dataM_addr");
        expectOutput(c + 2, F_LUS,  0,            "ld_stall_released");
        expectOutput(c + 2, F_FWDW, 32'hDEADBEEF, "ld_fwd_dataW");
        expectOutput(c + 2, F_WD,   32'hDEADBEEF, "ld_rf_wdata");
        expectOutput(c + 2, F_WA,   7,            "ld_rf_waddr");
        expectOutput(c + 3, F_FWDU, 32'hDEADBEEF, "ld_fwd_dataU");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'hDEADBEEF, 5'd7, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 5'd7, '0, 1'b0, 1'b0);
        bubble();

        // Load to x9 consumed via rs2
        applyStimulus(1'b1, 5'd9, 1'b1, 1'b1, 32'h200, '0, '0, '0, 1'b0, 1'b0);
        c = cyc;
        expectOutput(c + 1, F_LUS, 1,            "ld_stall_rs2");
        expectOutput(c + 2, F_WD,  32'hCAFE0000, "ld2_rf_wdata");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 32'hCAFE0000, 5'd1, 5'd9, 1'b0, 1'b0);
        repeat (3) bubble();

        // x0 destination: ALU write then a load, neither may enable a write or stall
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 32'hFF, '0, '0, '0, 1'b0, 1'b0);
        c = cyc;
        expectOutput(c + 1, F_RWM,  0,     "x0_RegWriteM");
        expectOutput(c + 1, F_FWDM, 32'hFF, "x0_fwd_dataM");
        expectOutput(c + 2, F_RWW,  0,     "x0_RegWriteW");
        expectOutput(c + 2, F_WE,   0,     "x0_rf_we");
        expectOutput(c + 3, F_RWU,  0,     "x0_RegWriteU");
        expectOutput(c + 3, F_FWDU, 32'hFF, "x0_fwd_dataU");
        expectOutput(c + 2, F_LUS,  0,     "x0_load_no_stall");
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b1, 32'h40, '0, '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (3) bubble();

        // Stall M for two cycles with rd=3 resident, then stall+flush together
        applyStimulus(1'b1, 5'd4, 1'b1, 1'b0, 32'h44, '0, '0, '0, 1'b0, 1'b0);
        c = cyc;
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 32'h33, '0, '0, '0, 1'b0, 1'b0);
        expectOutput(c + 2, F_RDM,  3,      "stall_rdM_enter");
        expectOutput(c + 2, F_RDW,  4,      "stall_rdW_prev");
        expectOutput(c + 3, F_RDM,  3,      "stall_rdM_hold1");
        expectOutput(c + 3, F_RWM,  1,      "stall_RegWriteM_hold1");
        expectOutput(c + 3, F_RWW,  0,      "stall_W_bubble1");
        expectOutput(c + 3, F_RWU,  1,      "stall_U_drain");
        expectOutput(c + 3, F_RDU,  4,      "stall_rdU_drain");
        expectOutput(c + 3, F_FWDU, 32'h44, "stall_fwd_dataU_drain");
        expectOutput(c + 4, F_RDM,  3,      "stall_rdM_hold2");
        expectOutput(c + 4, F_FWDM, 32'h33, "stall_fwd_dataM_hold2");
        expectOutput(c + 4, F_RWW,  0,      "stall_W_bubble2");
        expectOutput(c + 4, F_WE,   0,      "stall_rf_we_bubble2");
        expectOutput(c + 4, F_RWU,  0,      "stall_U_bubble");
        expectOutput(c + 5, F_RWM,  0,      "flush_M_cleared");
        expectOutput(c + 5, F_RDW,  3,      "flush_rdW");
        expectOutput(c + 5, F_RWW,  1,      "flush_RegWriteW");
        expectOutput(c + 5, F_WD,   32'h33, "flush_rf_wdata");
        expectOutput(c + 6, F_RWU,  1,      "flush_RegWriteU");
        expectOutput(c + 6, F_FWDU, 32'h33, "flush_fwd_dataU");
        expectOutput(c + 6, F_RWW,  0,      "flush_W_empty");
        applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, 32'h66, '0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, 32'h66, '0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, 32'h66, '0, '0, '0, 1'b1, 1'b1);
        repeat (3) bubble();

        // Flush alone kills the incoming instruction
        applyStimulus(1'b1, 5'd8, 1'b1, 1'b0, 32'h88, '0, '0, '0, 1'b0, 1'b1);
        c = cyc;
        expectOutput(c + 1, F_RWM, 0, "flushonly_RegWriteM");
        expectOutput(c + 2, F_WE,  0, "flushonly_rf_we");
        repeat (3) bubble();

        // Fill all stages, then drop reset mid-cycle
        applyStimulus(1'b1, 5'd1, 1'b1, 1'b0, 32'h11, '0, '0, '0, 1'b0, 1'b0);
        c = cyc;
        applyStimulus(1'b1, 5'd2, 1'b1, 1'b0, 32'h22, '0, '0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd11, 1'b1, 1'b1, 32'hBB, 32'h5A5A, 5'd11, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd12, 1'b1, 1'b0, 32'hCC, '0, 5'd11, '0, 1'b0, 1'b0);
        expectOutput(c + 3, F_RWM, 1,  "full_RegWriteM");
        expectOutput(c + 3, F_LUS, 1,  "full_load_use_stall");
        expectOutput(c + 3, F_RWW, 1,  "full_RegWriteW");
        expectOutput(c + 3, F_RWU, 1,  "full_RegWriteU");
        expectOutput(c + 3, F_RDU, 1,  "full_rdU");
        applyStimulus(1'b1, 5'd13, 1'b1, 1'b0, 32'hDD, 32'h5A5A, 5'd12, 5'd12, 1'b0, 1'b0);
        rst_n = 1'b0;
        for (int f = F_RDM; f <= F_LUS; f++) begin
            expectOutput(c + 4, f, 0, $sformatf("midrst_field%0d", f));
        end
`ifdef RETIRE_COUNT_EN
        expectOutput(c + 4, F_CNT, 0, "midrst_retired_cnt");
`endif
        bubble();
        bubble();
        rst_n = 1'b1;
        expectOutput(c + 6, F_WE,  0, "postrst_rf_we0");
        expectOutput(c + 6, F_RWM, 0, "postrst_RegWriteM");
        expectOutput(c + 7, F_WE,  0, "postrst_rf_we1");
        bubble();
        bubble();

        // 10 valid instructions interleaved with 3 bubbles, then drain
        for (int k = 0; k < 13; k++) begin
            if (k == 2 || k == 6 || k == 9) begin
                bubble();
            end else begin
                applyStimulus(1'b1, 5'(k + 1), 1'b1, 1'b0, 32'(k), '0, '0, '0, 1'b0, 1'b0);
            end
            if (k == 0) t0 = cyc;
        end
        expectOutput(t0 + 12 + 2, F_WA, 13, "seq_last_rf_waddr");
`ifdef RETIRE_COUNT_EN
        expectOutput(t0 + 3,      F_CNT, 1,  "cnt_first");
        expectOutput(t0 + 12 + 4, F_CNT, 10, "cnt_ten");
`endif
        repeat (4) bubble();

`ifdef RETIRE_COUNT_EN
        // Counter wrap: pipeline is drained so W is empty while preloading
        bubble();
        c = cyc;
        force dut.retiredCnt_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1 release dut.retiredCnt_q;
        expectOutput(c, F_CNT, 64'hFFFF_FFFF_FFFF_FFFE, "cnt_preload");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 5'd20, 1'b1, 1'b0, 32'h0, '0, '0, '0, 1'b0, 1'b0);
        end
        expectOutput(c + 4, F_CNT, 64'hFFFF_FFFF_FFFF_FFFF, "cnt_max");
        expectOutput(c + 5, F_CNT, 0,                       "cnt_wrap");
        expectOutput(c + 6, F_CNT, 1,                       "cnt_after_wrap");
        repeat (4) bubble();
`endif

        // Let the monitor consume everything still queued (bounded).
        for (int k = 0; k < 20 && scoreQ.size() > 0; k++) begin
            @(posedge clk);
        end
        while (scoreQ.size() > 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: got no check, expected one at cycle %0d",
                     scoreQ[0].name, scoreQ[0].cyc);
            scoreQ.delete(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/retire_pipe.md
Name: retire_pipe

Overview:
- Owns the post-execute pipeline registers (E→M, M→W, W→U) of the 6-stage core.
- Produces destination tags, write enables and forwarding data for the forwarding unit, plus the register-file write port.
- Operand muxes in E select the data outputs using forward_path_A/B codes 01=M, 10=W, 11=U.
- Also generates the load-use stall request for the hazard logic.

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- validE  in  1  E-stage slot holds a real instruction
- rdE  in  REG_AW  E-stage destination register
- RegWriteE  in  1  E-stage instruction writes rd
- MemReadE  in  1  E-stage instruction is a load
- alu_resultE  in  XLEN  E-stage ALU result
- load_dataM  in  XLEN  data memory read data for the M-stage load
- rs1E, rs2E  in  REG_AW each  sources of the instruction currently in E
- stall_m  in  1  hold the M stage
- flush_m  in  1  kill the instruction entering M
- rdM, rdW, rdU  out  REG_AW  stage destination tags
- RegWriteM, RegWriteW, RegWriteU  out  1  gated write enables
- fwd_dataM  out  XLEN  M-stage ALU result (forward code 01)
- fwd_dataW  out  XLEN  W-stage result (code 10)
- fwd_dataU  out  XLEN  U-stage result (code 11)
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_AW  register-file write address
- rf_wdata  out  XLEN  register-file write data
- load_use_stall  out  1  E consumer depends on an in-flight load in M

Behaviour:
- Per-stage state:
  - M: valid, rd, regwrite, memread, data.
  - W: valid, rd, regwrite, data.
  - U: valid, rd, regwrite, data.
- Reset (async, rst_n=0): all valid/regwrite/memread bits clear; rd and data fields clear to 0. All outputs therefore read 0.
- RegWriteX = validX & regwriteX & (rdX != 0). RegWrite is never asserted for x0.
- rdX is always presented raw.
- E→M on each clk edge:
  - flush_m=1: M.valid←0, whether or not stall_m is set. Flush has priority.
  - else stall_m=1: M holds all fields.
  - else M←{validE, rdE, RegWriteE, MemReadE, alu_resultE}.
- M→W on each clk edge:
  - If stall_m=1 and flush_m=0, W.valid←0 (bubble); M remains resident.
  - Otherwise W←{M.valid, M.rd, M.regwrite, M.memread ? load_dataM : M.data}.
- W→U: unconditional every cycle, U←W. No stall or flush.
- Write port: rf_we=RegWriteW, rf_waddr=rdW, rf_wdata=W.data.
  - U holds the value written last cycle, which covers the register file's read-before-write.
- fwd_dataM = M.data.
  - For a load this is the address and is not usable; load_use_stall covers that case.
- load_use_stall = M.valid & M.memread & (M.rd != 0) & ((M.rd == rs1E) | (M.rd == rs2E)), combinational.
  - Hazard logic converts it into stall of F/D/E plus bubble insertion.
  - It deasserts once the load reaches W.
- Latency: an E-stage result is visible as M data 1 cycle later, W 2, U 3.
  - rf write occurs on the edge ending the W cycle.
- Simultaneous flush_m & stall_m: treated as flush. M is cleared and W receives the old M contents.
- Reset mid-flight: everything is discarded immediately (asynchronous). No writes occur after rst_n falls.

Optional Feature:
- Macro: RETIRE_COUNT_EN
- Defined:
  - Adds output retired_cnt [63:0], reset to 0.
  - Increments by 1 on every edge where U will load a valid W entry (W.valid=1), bubbles excluded.
  - Wraps modulo 2^64.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset check: rst_n=0 mid-stream with all stages valid → every output reads 0 combinationally, with no edge required; rf_we=0 thereafter until new instructions arrive.
- ALU chain: validE=1, rdE=5, RegWriteE=1, alu_resultE=0x1234 for one cycle, then bubbles → expected progression:
  - cycle 1: rdM=5, RegWriteM=1, fwd_dataM=0x1234
  - cycle 2: rdW=5, rf_we=1, rf_waddr=5, rf_wdata=0x1234
  - cycle 3: RegWriteU=1, fwd_dataU=0x1234
  - cycle 4: all clear
- Load path: MemReadE=1, rdE=7, load_dataM=0xDEADBEEF, with rs1E=7 in the following cycle:
  - load_use_stall=1 during the M cycle.
  - Next cycle fwd_dataW=0xDEADBEEF and load_use_stall=0.
- x0 destination: rdE=0, RegWriteE=1, alu_resultE=0xFF → RegWriteM/W/U and rf_we remain 0 all cycles; load_use_stall=0 for a load to x0.
- Stall/flush:
  - Hold stall_m=1 for 2 cycles with M valid (rd=3) → M holds rd=3, W receives 2 bubbles (RegWriteW=0), U keeps draining.
  - Then assert stall_m=1 and flush_m=1 together → M.valid=0 next cycle, and W gets the rd=3 entry.
- With RETIRE_COUNT_EN: 10 valid instructions interleaved with 3 bubbles, then drain → retired_cnt=10. Preload near 2^64-1 via force → counter wraps to 0.
